// File: rtl/mul_seq_pkg.sv
// Shared op encodings, FSM state type and partial-product helpers for mul_seq.
package mul_seq_pkg;

  localparam logic [1:0] MUL_OP_MUL  = 2'b00;
  localparam logic [1:0] MUL_OP_MADD = 2'b01;
  localparam logic [1:0] MUL_OP_MSUB = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Aligns partial product k by the split points: |A| = 24+8, |B| = 17+15.
  function automatic logic [63:0] part_shift(input logic [1:0] k, input logic [40:0] p);
    logic [63:0] w;
    w = {23'd0, p};
    case (k)
      2'd0:    return w;
      2'd1:    return w << 17;
      2'd2:    return w << 24;
      default: return w << 41;
    endcase
  endfunction

endpackage

// File: rtl/dsp_mul.sv
// 24x17 unsigned multiplier with a registered product and clock-enable style hold.
module dsp_mul (
  input  logic        clk,
  input  logic        rstn,
  input  logic        a_wait,
  input  logic [23:0] a,
  input  logic [16:0] b,
  output logic [40:0] p
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p <= '0;
    end else if (!a_wait) begin
      p <= {17'd0, a} * {24'd0, b};
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Sequenced 32x32 MULT/MADD/MSUB unit: four 24x17 partial products through one dsp_mul.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        is_unsgn,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] hilo_in,
  input  logic        stall,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state;
  logic [31:0] ma;
  logic [31:0] mb;
  logic        neg;
  logic [1:0]  op_r;
  logic [63:0] hilo_r;
  logic [63:0] acc;
  logic [1:0]  cnt;
  logic        pend;
  logic [1:0]  pk;

  logic [23:0] dsp_a;
  logic [16:0] dsp_b;
  logic [40:0] prod;
  logic [63:0] mag;
  logic [63:0] result;

  // cnt[1] picks the high slice of |A|, cnt[0] the high slice of |B|.
  always_comb begin
    dsp_a = cnt[1] ? {16'd0, ma[31:24]} : ma[23:0];
    dsp_b = cnt[0] ? {2'd0, mb[31:17]}  : mb[16:0];
  end

  dsp_mul u_dsp_mul (
    .clk    (clk),
    .rstn   (~reset),
    .a_wait (stall),
    .a      (dsp_a),
    .b      (dsp_b),
    .p      (prod)
  );

  always_comb begin
    mag = neg ? (64'd0 - acc) : acc;
    case (op_r)
      MUL_OP_MADD: result = hilo_r + mag;
      MUL_OP_MSUB: result = hilo_r - mag;
      default:     result = mag;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      ma     <= '0;
      mb     <= '0;
      neg    <= 1'b0;
      op_r   <= '0;
      hilo_r <= '0;
      acc    <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
      pk     <= '0;
    end else if (cancel) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (!stall) begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            ma     <= abs32(src_a, ~is_unsgn);
            mb     <= abs32(src_b, ~is_unsgn);
            neg    <= ~is_unsgn & (src_a[31] ^ src_b[31]);
            op_r   <= op;
            hilo_r <= hilo_in;
            acc    <= '0;
            cnt    <= '0;
            pend   <= 1'b0;
            pk     <= '0;
            busy   <= 1'b1;
            state  <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          // pk tracks which partial product currently sits in the dsp_mul register.
          if (pend) acc <= acc + part_shift(pk, prod);
          if (pend && pk == 2'd3) begin
            state <= S_FIX;
          end else begin
            pend <= 1'b1;
            pk   <= cnt;
            cnt  <= cnt + 2'd1;
          end
        end
        S_FIX: begin
          {hi, lo} <= result;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq.
module tb_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        is_unsgn;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [63:0] hilo_in;
  logic        stall;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  mul_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .is_unsgn (is_unsgn),
    .src_a    (src_a),
    .src_b    (src_b),
    .hilo_in  (hilo_in),
    .stall    (stall),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] o, input logic u, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] h);
    op = o; is_unsgn = u; src_a = a; src_b = b; hilo_in = h;
  endtask

  task automatic launch(input logic [1:0] o, input logic u, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] h);
    set_op(o, u, a, b, h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic u,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] h);
    logic [63:0] ea, eb, p;
    ea = u ? {32'd0, a} : {{32{a[31]}}, a};
    eb = u ? {32'd0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    case (o)
      2'b01:   return h + p;
      2'b10:   return h - p;
      default: return p;
    endcase
  endfunction

  initial begin
    int lat;
    int seen;
    logic [63:0] prev;
    logic [1:0]  ro;
    logic        ru;
    logic [31:0] ra, rb;
    logic [63:0] rh;

    reset = 1'b1; start = 1'b0; stall = 1'b0; cancel = 1'b0;
    set_op(2'b00, 1'b0, '0, '0, '0);
    tick(); tick();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    tick();

    // 1: signed -1 * 2
    launch(2'b00, 1'b0, 32'hFFFF_FFFF, 32'h2, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    wait_done(lat);
    chk("t1_lat", lat, 6);
    chk("t1_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t1_busy_off", {63'd0, busy}, 64'd0);
    tick();
    chk("t1_done_drop", {63'd0, done}, 64'd0);

    // 2: unsigned same operands, then signed -2^31 squared
    launch(2'b00, 1'b1, 32'hFFFF_FFFF, 32'h2, 64'd0);
    wait_done(lat);
    chk("t2_lat", lat, 6);
    chk("t2_unsigned", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    launch(2'b00, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'd0);
    wait_done(lat);
    chk("t2_min_sq", {hi, lo}, 64'h4000_0000_0000_0000);

    // 3: MADD wrap and signed MSUB
    launch(2'b01, 1'b1, 32'h1, 32'h1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(lat);
    chk("t3_madd_wrap", {hi, lo}, 64'd0);
    launch(2'b10, 1'b0, 32'h3, 32'h5, 64'd0);
    wait_done(lat);
    chk("t3_msub", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // 4: three stalled cycles in CALC, then stall while in DONE
    launch(2'b00, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
    tick();
    stall = 1'b1;
    tick(); tick(); tick();
    stall = 1'b0;
    wait_done(lat);
    chk("t4_lat", lat + 4, 9);
    chk("t4_res", {hi, lo}, 64'h0B00_EA4E_242D_2080);
    stall = 1'b1;
    tick(); tick();
    chk("t4_done_hold", {63'd0, done}, 64'd1);
    chk("t4_hilo_hold", {hi, lo}, 64'h0B00_EA4E_242D_2080);
    stall = 1'b0;
    tick();
    chk("t4_done_drop", {63'd0, done}, 64'd0);

    // 5: cancel mid-CALC, then a fresh op
    prev = {hi, lo};
    launch(2'b00, 1'b1, 32'h7, 32'h9, 64'd0);
    tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_done", {63'd0, done}, 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) seen++;
    end
    chk("t5_no_done", seen, 0);
    chk("t5_hilo_kept", {hi, lo}, prev);
    launch(2'b00, 1'b0, 32'hFFFF_FFFD, 32'h7, 64'd0);
    wait_done(lat);
    chk("t5_new_lat", lat, 6);
    chk("t5_new_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // 6: async reset mid-CALC
    launch(2'b00, 1'b1, 32'h55, 32'h66, 64'd0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_done", {63'd0, done}, 64'd0);
    chk("t6_rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    tick();

    // 6b: back-to-back start in the DONE cycle
    launch(2'b00, 1'b1, 32'd10000, 32'd10000, 64'd0);
    wait_done(lat);
    chk("b2b_first", {hi, lo}, 64'h0000_0000_05F5_E100);
    set_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_done_drop", {63'd0, done}, 64'd0);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done(lat);
    chk("b2b_lat", lat, 6);
    chk("b2b_second", {hi, lo}, 64'h0000_0001_0000_0001);

    // random ops against the reference model
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ru = 1'($urandom_range(0, 1));
      ra = $urandom();
      rb = $urandom();
      rh = {$urandom(), $urandom()};
      launch(ro, ru, ra, rb, rh);
      wait_done(lat);
      chk("rand_lat", lat, 6);
      chk("rand_res", {hi, lo}, ref_model(ro, ru, ra, rb, rh));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
